gate_bank_reg: RTL and testbench

- Parametrised successor to the quad 2-input OR package.
- Provides CHANNELS independent 2-input gates, each WIDTH bits wide, with a run-time selectable function (OR/AND/XOR/NOR).
- Outputs are registered, with a capture enable.
- A built-in self-test (BIST) sequencer sweeps the full truth table of every function on every channel and reports pass/fail plus the first failing channel. It sits wherever discrete 74x08/32/86/02 packages would otherwise be instantiated.

---
 rtl/gate_bank_if.sv | 30 +++
 rtl/gate_bank_reg.sv | 143 ++++++++++++++
 tb/tb_gate_bank_reg.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/gate_bank_if.sv
// Operand/result bundle for gate_bank_reg: channel k occupies bits [k*WIDTH +: WIDTH].
// The driving side (a, b, fn, en, flt_inj, bist_start) is the master; the gate bank is the slave.
interface gate_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1
);
  localparam int FCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] a;
  logic [CHANNELS*WIDTH-1:0] b;
  logic [1:0]                fn;
  logic                      en;
  logic                      flt_inj;
  logic                      bist_start;
  logic [CHANNELS*WIDTH-1:0] y;
  logic                      bist_busy;
  logic                      bist_done;
  logic                      bist_fail;
  logic [FCW-1:0]            fail_ch;

  modport master (
    output a, b, fn, en, flt_inj, bist_start,
    input  y, bist_busy, bist_done, bist_fail, fail_ch
  );

  modport slave (
    input  a, b, fn, en, flt_inj, bist_start,
    output y, bist_busy, bist_done, bist_fail, fail_ch
  );
endinterface

// File: rtl/gate_bank_reg.sv
// Bank of CHANNELS registered 2-input gates (OR/AND/XOR/NOR) with a BIST
// sequencer that sweeps every function's truth table across all channels.
module gate_lane #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       fn,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (fn)
      2'b00:   y = a | b;
      2'b01:   y = a & b;
      2'b10:   y = a ^ b;
      default: y = ~(a | b);
    endcase
  end
endmodule

module gate_bank_reg #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 1
) (
  input  logic        clk,
  input  logic        clr_n,
  gate_bank_if.slave  bus
);
  localparam int FCW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

  state_t                       state;
  logic [3:0]                   v;
  logic [CHANNELS-1:0][WIDTH-1:0] op_a, op_b, gate_y, cap_y, y_q;
  logic [1:0]                   op_fn;
  logic                         tt;
  logic [CHANNELS-1:0]          mism;
  logic [FCW-1:0]               first_ch;
  logic                         busy_q, done_q, fail_q;
  logic [FCW-1:0]               fail_ch_q;

  // In APPLY the gates see all-a / all-b vectors derived from the counter.
  always_comb begin
    if (state == APPLY) begin
      op_a  = {(CHANNELS*WIDTH){v[1]}};
      op_b  = {(CHANNELS*WIDTH){v[0]}};
      op_fn = v[3:2];
    end else begin
      op_a  = bus.a;
      op_b  = bus.b;
      op_fn = bus.fn;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
    gate_lane #(.WIDTH(WIDTH)) u_lane (
      .a  (op_a[k]),
      .b  (op_b[k]),
      .fn (op_fn),
      .y  (gate_y[k])
    );
  end

  always_comb begin
    cap_y = gate_y;
    cap_y[CHANNELS-1][0] = gate_y[CHANNELS-1][0] ^ bus.flt_inj;
  end

  // Reference truth bit kept independent of the lanes so a broken lane is caught.
  always_comb begin
    case (v[3:2])
      2'b00:   tt = v[1] | v[0];
      2'b01:   tt = v[1] & v[0];
      2'b10:   tt = v[1] ^ v[0];
      default: tt = ~(v[1] | v[0]);
    endcase
  end

  always_comb begin
    for (int k = 0; k < CHANNELS; k++)
      mism[k] = (y_q[k] != {WIDTH{tt}});
  end

  always_comb begin
    first_ch = '0;
    for (int k = CHANNELS-1; k >= 0; k--)
      if (mism[k]) first_ch = FCW'(k);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= IDLE;
      v         <= '0;
      y_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= 1'b0;
      fail_ch_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.bist_start) begin
            state     <= APPLY;
            v         <= '0;
            fail_q    <= 1'b0;
            fail_ch_q <= '0;
            busy_q    <= 1'b1;
          end else if (bus.en) begin
            y_q <= cap_y;
          end
        end
        APPLY: begin
          y_q   <= cap_y;
          state <= CHECK;
        end
        CHECK: begin
          if (|mism && !fail_q) begin
            fail_q    <= 1'b1;
            fail_ch_q <= first_ch;
          end
          if (v == 4'd15) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            v     <= v + 4'd1;
            state <= APPLY;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.y         = y_q;
  assign bus.bist_busy = busy_q;
  assign bus.bist_done = done_q;
  assign bus.bist_fail = fail_q;
  assign bus.fail_ch   = fail_ch_q;
endmodule

// File: tb/tb_gate_bank_reg.sv
// Directed + randomized bench for gate_bank_reg: a 4x1 instance and a 3x8 instance
// checked against a plain arithmetic model of the gate bank and its BIST outcome.
module tb_gate_bank_reg;
  logic clk;
  logic clr_n;
  int   ntests = 0;
  int   nfail  = 0;

  gate_bank_if #(.CHANNELS(4), .WIDTH(1)) bus1();
  gate_bank_if #(.CHANNELS(3), .WIDTH(8)) bus2();

  gate_bank_reg #(.CHANNELS(4), .WIDTH(1)) dut1 (.clk(clk), .clr_n(clr_n), .bus(bus1.slave));
  gate_bank_reg #(.CHANNELS(3), .WIDTH(8)) dut2 (.clk(clk), .clr_n(clr_n), .bus(bus2.slave));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] gate_ref(input logic [1:0] f, input logic [63:0] a,
                                           input logic [63:0] b, input int bits);
    logic [63:0] r;
    case (f)
      2'd0: r = a | b;
      2'd1: r = a & b;
      2'd2: r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r & ((64'd1 << bits) - 64'd1);
  endfunction

  function automatic logic [63:0] get_y(input int d);
    return (d == 0) ? 64'(bus1.y) : 64'(bus2.y);
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? bus1.bist_busy : bus2.bist_busy;
  endfunction
  function automatic logic get_done(input int d);
    return (d == 0) ? bus1.bist_done : bus2.bist_done;
  endfunction
  function automatic logic get_fail(input int d);
    return (d == 0) ? bus1.bist_fail : bus2.bist_fail;
  endfunction
  function automatic logic [63:0] get_fch(input int d);
    return (d == 0) ? 64'(bus1.fail_ch) : 64'(bus2.fail_ch);
  endfunction

  task automatic set_start(input int d, input logic s);
    if (d == 0) bus1.bist_start = s; else bus2.bist_start = s;
  endtask

  task automatic scramble(input int d, input logic e);
    if (d == 0) begin
      bus1.a = 4'($urandom); bus1.b = 4'($urandom); bus1.fn = 2'($urandom); bus1.en = e;
    end else begin
      bus2.a = 24'($urandom); bus2.b = 24'($urandom); bus2.fn = 2'($urandom); bus2.en = e;
    end
  endtask

  // One full self-test: start (with EN also high), then watch busy/done for 40 cycles.
  task automatic run_bist(input int d, input logic flt, input logic [63:0] yprev,
                          input logic exp_fail, input logic [63:0] exp_fch,
                          input logic [63:0] exp_y);
    int busy_n = 0;
    int done_n = 0;
    int done_at = -1;
    if (d == 0) bus1.flt_inj = flt; else bus2.flt_inj = flt;
    scramble(d, 1'b1);
    set_start(d, 1'b1);
    tick();
    set_start(d, 1'b0);
    scramble(d, 1'b0);
    chk("start_priority_y", get_y(d), yprev);
    chk("start_clears_fail", {63'd0, get_fail(d)}, 64'd0);
    chk("start_clears_fch", get_fch(d), 64'd0);
    for (int k = 0; k < 40; k++) begin
      if (get_busy(d)) busy_n++;
      if (get_done(d)) begin done_n++; done_at = k; end
      if (k == 2) chk("fail_after_first_check", {63'd0, get_fail(d)}, {63'd0, exp_fail});
      set_start(d, k == 5);
      scramble(d, 1'b0);
      tick();
    end
    chk("busy_cycles", 64'(busy_n), 64'd32);
    chk("done_pulses", 64'(done_n), 64'd1);
    chk("done_cycle", 64'(done_at), 64'd32);
    chk("bist_fail", {63'd0, get_fail(d)}, {63'd0, exp_fail});
    chk("fail_ch", get_fch(d), exp_fch);
    chk("post_bist_y", get_y(d), exp_y);
  endtask

  initial begin
    logic [63:0] exp1, exp2;
    logic [3:0]  a1, b1;
    logic [23:0] a2, b2;
    logic [1:0]  f1, f2;
    logic        e1, e2, i1, i2;
    logic [3:0]  fn_exp [4];
    int          done_n;

    clr_n = 1'b0;
    bus1.a = '0; bus1.b = '0; bus1.fn = '0; bus1.en = 1'b0; bus1.flt_inj = 1'b0; bus1.bist_start = 1'b0;
    bus2.a = '0; bus2.b = '0; bus2.fn = '0; bus2.en = 1'b0; bus2.flt_inj = 1'b0; bus2.bist_start = 1'b0;
    #3;
    chk("rst_y1", get_y(0), 64'd0);
    chk("rst_y2", get_y(1), 64'd0);
    chk("rst_busy", {63'd0, get_busy(0)}, 64'd0);
    chk("rst_done", {63'd0, get_done(0)}, 64'd0);
    chk("rst_fail", {63'd0, get_fail(0)}, 64'd0);
    chk("rst_fch", get_fch(0), 64'd0);
    tick(); tick();
    clr_n = 1'b1;
    tick();

    // Directed AND capture, then EN=0 hold.
    bus1.fn = 2'b01; bus1.en = 1'b1; bus1.a = 4'b1011; bus1.b = 4'b1110;
    tick();
    chk("and_directed", get_y(0), 64'b1010);
    bus1.en = 1'b0; bus1.a = 4'b0101; bus1.b = 4'b0101;
    tick();
    chk("en_low_hold", get_y(0), 64'b1010);

    fn_exp[0] = 4'b0111; fn_exp[1] = 4'b0001; fn_exp[2] = 4'b0110; fn_exp[3] = 4'b1000;
    bus1.en = 1'b1; bus1.a = 4'b0101; bus1.b = 4'b0011;
    for (int f = 0; f < 4; f++) begin
      bus1.fn = 2'(f);
      tick();
      chk($sformatf("fn_code_%0d", f), get_y(0), 64'(fn_exp[f]));
    end
    exp1 = 64'b1000;
    exp2 = 64'd0;

    // Random normal-mode traffic on both banks.
    for (int n = 0; n < 24; n++) begin
      a1 = 4'($urandom); b1 = 4'($urandom); f1 = 2'($urandom);
      e1 = ($urandom_range(0, 3) != 0); i1 = ($urandom_range(0, 3) == 0);
      a2 = 24'($urandom); b2 = 24'($urandom); f2 = 2'($urandom);
      e2 = ($urandom_range(0, 3) != 0); i2 = ($urandom_range(0, 3) == 0);
      bus1.a = a1; bus1.b = b1; bus1.fn = f1; bus1.en = e1; bus1.flt_inj = i1;
      bus2.a = a2; bus2.b = b2; bus2.fn = f2; bus2.en = e2; bus2.flt_inj = i2;
      if (e1) exp1 = gate_ref(f1, 64'(a1), 64'(b1), 4) ^ (i1 ? 64'd8 : 64'd0);
      if (e2) exp2 = gate_ref(f2, 64'(a2), 64'(b2), 24) ^ (i2 ? (64'd1 << 16) : 64'd0);
      tick();
      chk($sformatf("rand1_%0d", n), get_y(0), exp1);
      chk($sformatf("rand2_%0d", n), get_y(1), exp2);
    end
    bus1.en = 1'b0; bus1.flt_inj = 1'b0;
    bus2.en = 1'b0; bus2.flt_inj = 1'b0;

    run_bist(0, 1'b0, exp1, 1'b0, 64'd0, 64'd0);
    run_bist(0, 1'b1, 64'd0, 1'b1, 64'd3, 64'd8);
    run_bist(0, 1'b0, 64'd8, 1'b0, 64'd0, 64'd0);
    run_bist(1, 1'b1, exp2, 1'b1, 64'd2, 64'd1 << 16);
    run_bist(1, 1'b0, 64'd1 << 16, 1'b0, 64'd0, 64'd0);

    // Reset ten cycles into a faulty BIST: everything clears at once, no DONE follows.
    bus1.flt_inj = 1'b1;
    bus1.bist_start = 1'b1;
    tick();
    bus1.bist_start = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("midrun_fail_set", {63'd0, get_fail(0)}, 64'd1);
    clr_n = 1'b0;
    #1;
    chk("midrun_rst_y", get_y(0), 64'd0);
    chk("midrun_rst_busy", {63'd0, get_busy(0)}, 64'd0);
    chk("midrun_rst_done", {63'd0, get_done(0)}, 64'd0);
    chk("midrun_rst_fail", {63'd0, get_fail(0)}, 64'd0);
    chk("midrun_rst_fch", get_fch(0), 64'd0);
    bus1.flt_inj = 1'b0;
    tick(); tick();
    clr_n = 1'b1;
    done_n = 0;
    for (int k = 0; k < 40; k++) begin
      if (get_done(0) || get_busy(0)) done_n++;
      tick();
    end
    chk("no_done_after_abort", 64'(done_n), 64'd0);
    run_bist(0, 1'b0, 64'd0, 1'b0, 64'd0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
